uart_rx_fifo: RTL and testbench

// - Receive-side buffer directly downstream of the UART receiver. Captures each good frame (dout on rx_done)

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_fifo_mem.sv | 26 ++
 rtl/uart_rx_fifo.sv | 95 +++++++++
 tb/tb_uart_rx_fifo.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame width, parity encodings and oversampling rate.
package uart_pkg;
  localparam int DATA_WD           = 8;
  localparam int OVERSAMPLING_RATE = 16;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;
endpackage

// File: rtl/uart_fifo_mem.sv
// Dual-port register array: synchronous write, registered read. Contents are never reset.
import uart_pkg::*;

module uart_fifo_mem #(
  parameter  int data_wd = DATA_WD,
  parameter  int depth   = 16,
  localparam int AW      = $clog2(depth)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [data_wd-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [data_wd-1:0] rdata
);
  logic [data_wd-1:0] mem [depth];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk)
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: pushes good frames, pops on request, counts
// receiver error events and holds off rx_start while no slot is free.
import uart_pkg::*;

module uart_rx_fifo #(
  parameter  int data_wd    = DATA_WD,
  parameter  int depth      = 16,
  parameter  int err_cnt_wd = 8,
  localparam int AW         = $clog2(depth),
  localparam int CW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_enable,
  input  logic                  rx_done,
  input  logic [data_wd-1:0]    rx_data,
  input  logic                  parity_error_flag,
  input  logic                  framing_error_flag,
  output logic                  rx_start,
  input  logic                  rd_en,
  output logic [data_wd-1:0]    rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  input  logic                  clr_status,
  output logic [err_cnt_wd-1:0] parity_err_cnt,
  output logic [err_cnt_wd-1:0] framing_err_cnt
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_next;
  logic          rx_done_q, pe_q, fe_q;
  logic          push_req, push, pop, drop, pe_rise, fe_rise;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(depth));
  assign count = count_q;

  // A frame flagged as errored is never buffered, even if rx_done pulses with it.
  assign push_req = rx_done & ~rx_done_q & ~parity_error_flag & ~framing_error_flag;
  assign pop      = rd_en & ~empty;
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;
  assign pe_rise  = parity_error_flag & ~pe_q;
  assign fe_rise  = framing_error_flag & ~fe_q;

  assign count_next = count_q + CW'(push) - CW'(pop);

  uart_fifo_mem #(.data_wd(data_wd), .depth(depth)) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (push & ~rst),
    .waddr(wr_ptr),
    .wdata(rx_data),
    .re   (pop),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      rd_valid  <= 1'b0;
      rx_start  <= 1'b0;
      rx_done_q <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q   <= count_next;
      rd_valid  <= pop;
      rx_start  <= rx_enable & (count_next < CW'(depth)) & ~rx_done;
      rx_done_q <= rx_done;
      pe_q      <= parity_error_flag;
      fe_q      <= framing_error_flag;
    end
  end

  // Status: clear beats any event arriving in the same cycle; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr_status) begin
      overflow        <= 1'b0;
      parity_err_cnt  <= '0;
      framing_err_cnt <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (pe_rise && parity_err_cnt != '1)  parity_err_cnt  <= parity_err_cnt + 1'b1;
      if (fe_rise && framing_err_cnt != '1) framing_err_cnt <= framing_err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner sequences, and
// randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DW = 8, DEPTH = 16, EW = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic rx_enable = 0, rx_done = 0, parity_error_flag = 0, framing_error_flag = 0;
  logic rd_en = 0, clr_status = 0;
  logic [DW-1:0] rx_data = '0;
  logic rx_start, rd_valid, empty, full, overflow;
  logic [DW-1:0] rd_data;
  logic [4:0] count;
  logic [EW-1:0] parity_err_cnt, framing_err_cnt;

  int n_chk = 0, n_fail = 0;

  uart_rx_fifo #(.data_wd(DW), .depth(DEPTH), .err_cnt_wd(EW)) dut (
    .clk(clk), .rst(rst), .rx_enable(rx_enable), .rx_done(rx_done), .rx_data(rx_data),
    .parity_error_flag(parity_error_flag), .framing_error_flag(framing_error_flag),
    .rx_start(rx_start), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .full(full), .count(count), .overflow(overflow), .clr_status(clr_status),
    .parity_err_cnt(parity_err_cnt), .framing_err_cnt(framing_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1; rx_done = 0; rd_en = 0; clr_status = 0;
    parity_error_flag = 0; framing_error_flag = 0;
    step(); step();
    rst = 0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    rx_done = 1; rx_data = d; step();
    rx_done = 0; step();
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    rd_en = 1; step(); rd_en = 0;
    chk({nm, " rd_valid"}, rd_valid, 1);
    chk({nm, " rd_data"}, rd_data, exp);
  endtask

  // ---------------- reference model (plain queue) ----------------
  logic [7:0] q[$];
  logic prev_done;
  bit   ovf_m;
  int   pops_m;

  task automatic model_sync();
    q.delete(); prev_done = 0; ovf_m = 0; pops_m = 0;
  endtask

  task automatic rand_step(input logic d, input logic [7:0] data, input logic r, input logic en);
    logic rise, do_pop;
    logic [7:0] exp_d;
    rise   = d && !prev_done;
    do_pop = r && q.size() > 0;
    exp_d  = 8'h00;
    rx_done = d; rx_data = data; rd_en = r; rx_enable = en;
    if (do_pop) begin exp_d = q.pop_front(); pops_m++; end
    if (rise) begin
      if (q.size() < DEPTH) q.push_back(data);
      else ovf_m = 1;
    end
    prev_done = d;
    step();
    chk("rnd count", count, q.size());
    chk("rnd empty", empty, q.size() == 0);
    chk("rnd full", full, q.size() == DEPTH);
    chk("rnd rd_valid", rd_valid, do_pop);
    if (do_pop) chk("rnd rd_data", rd_data, exp_d);
    chk("rnd overflow", overflow, ovf_m);
    chk("rnd rx_start", rx_start, en && q.size() < DEPTH && !d);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       done;
    logic [7:0] data;
    logic       rd;
    int         exp_count;
    logic       exp_empty;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vt[8];

  initial begin
    // rx_done held 3 cycles writes once; pop returns the byte one cycle later.
    vt[0] = '{1, 8'hA5, 0, 1, 0, 0, 8'h00};
    vt[1] = '{1, 8'h11, 0, 1, 0, 0, 8'h00};
    vt[2] = '{1, 8'h22, 0, 1, 0, 0, 8'h00};
    vt[3] = '{0, 8'h00, 0, 1, 0, 0, 8'h00};
    vt[4] = '{0, 8'h00, 1, 0, 1, 1, 8'hA5};
    vt[5] = '{0, 8'h00, 1, 0, 1, 0, 8'hA5};
    vt[6] = '{1, 8'h3C, 1, 1, 0, 0, 8'hA5};
    vt[7] = '{0, 8'h00, 1, 0, 1, 1, 8'h3C};

    do_reset();
    chk("reset empty", empty, 1);
    chk("reset count", count, 0);
    chk("reset full", full, 0);
    chk("reset rx_start", rx_start, 0);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset overflow", overflow, 0);
    chk("reset pe_cnt", parity_err_cnt, 0);
    chk("reset fe_cnt", framing_err_cnt, 0);
    step();
    chk("idle rx_start", rx_start, 0);
    rx_enable = 1; step();
    chk("enable rx_start", rx_start, 1);

    for (int i = 0; i < 8; i++) begin
      rx_done = vt[i].done; rx_data = vt[i].data; rd_en = vt[i].rd;
      step();
      chk($sformatf("vec%0d count", i), count, vt[i].exp_count);
      chk($sformatf("vec%0d empty", i), empty, vt[i].exp_empty);
      chk($sformatf("vec%0d rd_valid", i), rd_valid, vt[i].exp_valid);
      chk($sformatf("vec%0d rd_data", i), rd_data, vt[i].exp_data);
    end
    rx_done = 0; rd_en = 0; step();

    // Fill to full, then overflow with a 17th byte.
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i));
      if (i == 14) chk("15 rx_start", rx_start, 1);
    end
    chk("fill full", full, 1);
    chk("fill count", count, 16);
    chk("fill rx_start", rx_start, 0);
    push_byte(8'hFF);
    chk("ovf overflow", overflow, 1);
    chk("ovf count", count, 16);
    for (int i = 0; i < 16; i++) begin
      pop_chk($sformatf("drain%0d", i), 8'(i));
      if (i == 0) chk("drain0 rx_start", rx_start, 1);
    end
    step();
    chk("drain empty", empty, 1);
    chk("drain rd_valid", rd_valid, 0);
    rd_en = 1; step(); rd_en = 0;
    chk("underflow rd_valid", rd_valid, 0);
    chk("underflow count", count, 0);
    chk("sticky overflow", overflow, 1);
    clr_status = 1; step(); clr_status = 0;
    chk("clr overflow", overflow, 0);

    // Full with simultaneous push+pop: accepted, no overflow, new byte last.
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    rx_done = 1; rx_data = 8'h55; rd_en = 1; step();
    rx_done = 0; rd_en = 0;
    chk("fullpp rd_data", rd_data, 8'h00);
    chk("fullpp count", count, 16);
    chk("fullpp overflow", overflow, 0);
    step();
    for (int i = 1; i < 16; i++) pop_chk($sformatf("fpp%0d", i), 8'(i));
    pop_chk("fpp last", 8'h55);

    // Empty with simultaneous push+pop: push only, no bypass.
    step();
    rx_done = 1; rx_data = 8'h77; rd_en = 1; step();
    rx_done = 0; rd_en = 0;
    chk("emptypp rd_valid", rd_valid, 0);
    chk("emptypp count", count, 1);
    step();
    pop_chk("emptypp pop", 8'h77);

    // Reset mid-stream discards buffered data.
    push_byte(8'h01); push_byte(8'h02);
    do_reset();
    chk("midrst count", count, 0);
    chk("midrst empty", empty, 1);

    // Error counters: both flags rising together count both; framing saturates.
    rx_enable = 1;
    for (int i = 0; i < 300; i++) begin
      framing_error_flag = 1; parity_error_flag = (i < 2);
      rx_done = (i == 5); rx_data = 8'hEE;
      step();
      framing_error_flag = 0; parity_error_flag = 0; rx_done = 0;
      step();
      if (i == 9) chk("fe_cnt 10", framing_err_cnt, 10);
    end
    chk("errored frame no push", count, 0);
    chk("fe_cnt sat", framing_err_cnt, 255);
    chk("pe_cnt", parity_err_cnt, 2);
    clr_status = 1; framing_error_flag = 1; parity_error_flag = 1; step();
    clr_status = 0; framing_error_flag = 0; parity_error_flag = 0;
    chk("clr fe_cnt", framing_err_cnt, 0);
    chk("clr pe_cnt", parity_err_cnt, 0);
    chk("clr overflow", overflow, 0);

    // Wrap: interleave 40 bytes around occupancy 3.
    do_reset(); model_sync();
    begin
      int cyc = 0;
      int pushed = 0;
      while ((pops_m < 40) && cyc < 1000) begin
        logic d;
        d = !prev_done && (pushed < 40) && ($urandom_range(0, 1) == 1);
        if (d) pushed++;
        rand_step(d, 8'($urandom), q.size() >= 3 || pushed >= 40, 1);
        cyc++;
      end
      chk("wrap popped 40", pops_m >= 40, 1);
      chk("wrap no overflow", overflow, 0);
    end

    // Free random traffic, pushes outpacing pops so the full boundary is exercised.
    do_reset(); model_sync();
    for (int i = 0; i < 1500; i++)
      rand_step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) == 0,
                $urandom_range(0, 7) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
